// File: rtl/chanbuf_pkg.sv
// chanbuf_pkg: shared widths, arbiter state type and burst counter width
package chanbuf_pkg;
    localparam int CB_ADDR_W = 9;
    localparam int CB_DATA_W = 8;
    localparam int BURST_W   = 8;
    typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search over an eligible mask
// i_elig: candidate mask, i_ptr: first index searched
// o_oh/o_idx: winner as one-hot and index, o_found: any candidate present
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] i_elig,
    input  logic [2:0]       i_ptr,
    output logic [N_REQ-1:0] o_oh,
    output logic [2:0]       o_idx,
    output logic             o_found
);
    logic [2*N_REQ-1:0] w_rot;
    logic [3:0]         w_sum;
    // Rotating a doubled mask puts the pointer at bit 0, so the search is a plain priority scan.
    always_comb begin
        w_rot   = {i_elig, i_elig} >> i_ptr;
        o_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!o_found && w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + 4'(k);
            end
        end
        o_idx = (w_sum >= 4'(N_REQ)) ? 3'(w_sum - 4'(N_REQ)) : 3'(w_sum);
        o_oh  = o_found ? {{(N_REQ-1){1'b0}}, 1'b1} << o_idx : '0;
    end
endmodule

// File: rtl/chanbuf_arbiter.sv
// chanbuf_arbiter: round-robin arbiter with bounded burst lock for the channel buffer RAM port
// req/lock/we/addr/wdata: per-requester access requests (packed per requester)
// gnt/rvalid/rdata: per-requester issue pulse, read-return pulse and broadcast read data
// owner/locked: last granted requester and burst-lock status
// chanbuf_*: single RAM port, read data returns the cycle after chanbuf_clken
module chanbuf_arbiter
    import chanbuf_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = CB_ADDR_W,
    parameter int DATA_W    = CB_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [2:0]              owner,
    output logic                    locked,
    output logic                    chanbuf_clken,
    output logic                    chanbuf_we,
    output logic [ADDR_W-1:0]       chanbuf_addr,
    output logic [DATA_W-1:0]       chanbuf_data_w,
    input  logic [DATA_W-1:0]       chanbuf_data_r
);
    arb_state_t         r_state;
    arb_state_t         w_state_nx;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nx;
    logic [BURST_W-1:0] w_burst_inc;
    logic [2:0]         r_ptr;
    logic [2:0]         r_owner;
    logic [N_REQ-1:0]   r_own_oh;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_rvalid;
    logic               r_clken;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               w_release;
    logic               w_lock_eff;
    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_win_oh;
    logic [2:0]         w_win_idx;
    logic               w_found;
    logic               w_win_lock;
    logic               w_win_we;
    logic [2:0]         w_ptr_nx;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    // A grant still visible to the owner means its inputs are stale, so release waits for a quiet cycle.
    assign w_release   = (r_state == LOCKED) && !(|(r_gnt & r_own_oh)) && !(|(req & lock & r_own_oh));
    assign w_lock_eff  = (r_state == LOCKED) && !w_release;
    assign w_elig      = req & ~r_gnt & (w_lock_eff ? r_own_oh : '1);
    assign w_win_lock  = |(w_win_oh & lock);
    assign w_win_we    = |(w_win_oh & we);
    assign w_burst_inc = r_burst + BURST_W'(1);
    assign w_ptr_nx    = (w_win_idx == 3'(N_REQ - 1)) ? 3'd0 : w_win_idx + 3'd1;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_oh    (w_win_oh),
        .o_idx   (w_win_idx),
        .o_found (w_found)
    );

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_win_oh[k]) begin
                w_addr  = addr[k*ADDR_W +: ADDR_W];
                w_wdata = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // The cap releases on the grant that reaches it; a lock with MAX_BURST of 1 never holds.
    always_comb begin
        w_state_nx = w_lock_eff ? LOCKED : IDLE;
        w_burst_nx = r_burst;
        if (w_found && w_lock_eff) begin
            w_burst_nx = w_burst_inc;
            w_state_nx = (w_burst_inc == BURST_W'(MAX_BURST)) ? IDLE : LOCKED;
        end else if (w_found && w_win_lock && MAX_BURST > 1) begin
            w_burst_nx = BURST_W'(1);
            w_state_nx = LOCKED;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_burst  <= '0;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_own_oh <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_clken  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_burst  <= w_burst_nx;
            r_gnt    <= w_win_oh;
            r_clken  <= w_found;
            r_we     <= w_found & w_win_we;
            r_rvalid <= (r_clken && !r_we) ? r_gnt : '0;
            if (w_found) begin
                r_ptr    <= w_ptr_nx;
                r_owner  <= w_win_idx;
                r_own_oh <= w_win_oh;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
            end
        end
    end

    assign gnt            = r_gnt;
    assign rvalid         = r_rvalid;
    assign rdata          = (|r_rvalid) ? chanbuf_data_r : '0;
    assign owner          = r_owner;
    assign locked         = (r_state == LOCKED);
    assign chanbuf_clken  = r_clken;
    assign chanbuf_we     = r_we;
    assign chanbuf_addr   = r_addr;
    assign chanbuf_data_w = r_wdata;
endmodule

// File: tb/tb_chanbuf_arbiter.sv
// tb_chanbuf_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_chanbuf_arbiter;
    localparam int N    = 4;
    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic [2:0]      owner;
    logic            locked;
    logic            chanbuf_clken, chanbuf_we;
    logic [AW-1:0]   chanbuf_addr;
    logic [DW-1:0]   chanbuf_data_w;
    logic [DW-1:0]   chanbuf_data_r;

    logic [DW-1:0]   ram [512];
    logic [DW-1:0]   ram_q;

    int n_chk = 0;
    int n_fail = 0;

    int            m_gnt, m_rv, m_owner, m_ptr, m_cnt;
    bit            m_clken, m_we, m_locked;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdq, m_rdexp;
    logic [DW-1:0] ref_mem [512];

    chanbuf_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .req            (req),
        .lock           (lock),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .owner          (owner),
        .locked         (locked),
        .chanbuf_clken  (chanbuf_clken),
        .chanbuf_we     (chanbuf_we),
        .chanbuf_addr   (chanbuf_addr),
        .chanbuf_data_w (chanbuf_data_w),
        .chanbuf_data_r (chanbuf_data_r)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 9'h05A) ? 8'h3C : 8'(a * 9'd37 + 9'd11);
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i < 0) ? '0 : N'(1 << i);
    endfunction

    always @(posedge clk) begin
        if (rst_in) begin
            for (int a = 0; a < 512; a++) ram[a] <= init_val(9'(a));
        end else if (chanbuf_clken) begin
            if (chanbuf_we) ram[chanbuf_addr] <= chanbuf_data_w;
            else ram_q <= ram[chanbuf_addr];
        end
    end
    assign chanbuf_data_r = ram_q;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model of the arbiter rules: advances one clock from the current inputs.
    task automatic model_eval();
        int win, o, i;
        bit lk;
        if (rst_in) begin
            m_gnt = -1; m_rv = -1; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_clken = 0; m_we = 0; m_locked = 0;
            m_addr = '0; m_wd = '0; m_rdexp = '0;
            for (int a = 0; a < 512; a++) ref_mem[a] = init_val(9'(a));
            return;
        end
        m_rv = (m_clken && !m_we) ? m_gnt : -1;
        m_rdexp = m_rdq;
        o = m_owner;
        lk = m_locked;
        if (lk && m_gnt != o && !(req[o] && lock[o])) lk = 0;
        win = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (win < 0 && req[i] && m_gnt != i && (!lk || i == o)) win = i;
        end
        m_gnt = win;
        if (win < 0) begin
            m_clken = 0;
            m_we = 0;
        end else begin
            m_clken = 1;
            m_we = we[win];
            m_addr = addr[win*AW +: AW];
            m_wd = wdata[win*DW +: DW];
            m_owner = win;
            m_ptr = (win + 1) % N;
            if (lk) begin
                m_cnt++;
                if (m_cnt == MAXB) lk = 0;
            end else if (lock[win]) begin
                lk = 1;
                m_cnt = 1;
            end
            if (m_we) ref_mem[m_addr] = m_wd;
            else m_rdq = ref_mem[m_addr];
        end
        m_locked = lk;
    endtask

    task automatic check_all();
        check("gnt", 32'(gnt), 32'(oh(m_gnt)));
        check("rvalid", 32'(rvalid), 32'(oh(m_rv)));
        check("clken", 32'(chanbuf_clken), 32'(m_clken));
        check("we", 32'(chanbuf_we), 32'(m_we));
        check("addr", 32'(chanbuf_addr), 32'(m_addr));
        check("data_w", 32'(chanbuf_data_w), 32'(m_wd));
        check("owner", 32'(owner), 32'(m_owner));
        check("locked", 32'(locked), 32'(m_locked));
        if (m_rv >= 0) check("rdata", 32'(rdata), 32'(m_rdexp));
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req = '0;
        lock = '0;
        we = '0;
        step();
        rst_in = 1'b0;
    endtask

    initial begin
        int n1;
        bit seen3;
        int fair_exp [5] = '{0, 1, 2, 3, 0};
        m_rdq = '0;
        addr = '0;
        wdata = '0;
        do_reset();
        check("rst_rdata", 32'(rdata), 32'd0);

        req = 4'b0001;
        addr[0 +: AW] = 9'h05A;
        step();
        check("sr_gnt", 32'(gnt), 32'h1);
        check("sr_addr", 32'(chanbuf_addr), 32'h05A);
        req = '0;
        step();
        check("sr_rvalid", 32'(rvalid), 32'h1);
        check("sr_rdata", 32'(rdata), 32'h3C);

        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("fair_gnt", 32'(gnt), 32'(oh(fair_exp[k])));
            check("fair_clken", 32'(chanbuf_clken), 32'd1);
        end

        do_reset();
        req = 4'b0100;
        we = 4'b0100;
        addr[2*AW +: AW] = 9'h1FF;
        wdata[2*DW +: DW] = 8'hA5;
        step();
        check("wr_we", 32'(chanbuf_we), 32'd1);
        we = '0;
        step();
        check("wr_gap", 32'(gnt), 32'd0);
        step();
        check("rd_gnt", 32'(gnt), 32'h4);
        check("rd_we", 32'(chanbuf_we), 32'd0);
        req = '0;
        step();
        check("rd_rvalid", 32'(rvalid), 32'h4);
        check("rd_rdata", 32'(rdata), 32'hA5);

        do_reset();
        req = 4'b1010;
        lock = 4'b0010;
        n1 = 0;
        seen3 = 0;
        for (int c = 0; c < 60 && !seen3; c++) begin
            step();
            if (gnt[1]) n1++;
            if (gnt[3]) begin
                seen3 = 1;
                check("burst_cnt", 32'(n1), 32'd16);
                check("burst_unlock", 32'(locked), 32'd0);
            end
        end
        if (!seen3) check("burst_timeout", 32'd0, 32'd1);

        do_reset();
        req = 4'b1010;
        lock = 4'b0010;
        n1 = 0;
        for (int c = 0; c < 30 && n1 < 5; c++) begin
            step();
            if (gnt[1]) n1++;
        end
        check("early_n1", 32'(n1), 32'd5);
        lock = '0;
        step();
        step();
        check("early_gnt", 32'(gnt), 32'h8);
        check("early_unlock", 32'(locked), 32'd0);

        do_reset();
        req = 4'b0001;
        step();
        rst_in = 1'b1;
        req = '0;
        step();
        check("mr_rvalid", 32'(rvalid), 32'd0);
        check("mr_clken", 32'(chanbuf_clken), 32'd0);
        check("mr_rdata", 32'(rdata), 32'd0);
        rst_in = 1'b0;
        req = 4'b1111;
        step();
        check("mr_next", 32'(gnt), 32'h1);

        lock = '0;
        for (int c = 0; c < 3000; c++) begin
            rst_in = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 19) == 0) lock[i] = ~lock[i];
                req[i] = lock[i] ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
                we[i] = 1'($urandom_range(0, 1));
                addr[i*AW +: AW] = 9'($urandom_range(0, 15));
                wdata[i*DW +: DW] = 8'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/chanbuf_arbiter.md
Name: chanbuf_arbiter

Overview:
Shares one channel buffer RAM port between up to N_REQ requesters: SPI module controllers, the LED refresh scanner and the takeover path.
Issues at most one RAM access per clock.
Grants requesters in round-robin order, with an optional bounded burst lock so a multi-byte READ/WRITE stream can hold the buffer.
Sits between the requesters and the channel buffer RAM, replacing direct controller-to-RAM wiring.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 9, channel buffer address width
DATA_W, 8, channel buffer data width
MAX_BURST, 16, maximum consecutive grants to one locked owner before forced release (1..255)

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst_in  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester access request, held until gnt or withdrawn
lock  in  N_REQ  per-requester burst lock request, qualified by req
we  in  N_REQ  per-requester write enable
addr  in  N_REQ*ADDR_W  per-requester address, packed, requester i at [i*ADDR_W +: ADDR_W]
wdata  in  N_REQ*DATA_W  per-requester write data, packed
gnt  out  N_REQ  one-hot, one-cycle pulse: access issued
rvalid  out  N_REQ  one-hot, one-cycle pulse: rdata valid for that requester
rdata  out  DATA_W  read data broadcast to all requesters
owner  out  3  index of the last granted requester
locked  out  1  high while in the LOCKED state
chanbuf_clken  out  1  RAM clock enable / access strobe
chanbuf_we  out  1  RAM write enable
chanbuf_addr  out  ADDR_W  RAM address
chanbuf_data_w  out  DATA_W  RAM write data
chanbuf_data_r  in  DATA_W  RAM read data, valid the cycle after chanbuf_clken

Behaviour:
- Reset: every output is 0, the round-robin pointer is 0, state is IDLE, and the read pipeline is flushed. A read issued before reset never produces rvalid.
- Eligibility in cycle t: req[i]=1 and gnt[i]=0. A requester is never granted in two consecutive cycles, because gnt is registered and the requester sees it late.
- Arbitration is round-robin. The search starts at the pointer; the first eligible index wins.
  - On a grant to i, the pointer becomes (i+1) mod N_REQ.
  - If nothing is eligible, nothing is issued.
- Issue registered at the edge ending cycle t:
  - gnt[i]=1 and chanbuf_clken=1.
  - chanbuf_addr, chanbuf_we and chanbuf_data_w are copied from requester i; owner=i.
  - All of these are held for exactly one cycle. When idle, chanbuf_clken=0 and chanbuf_we=0; addr and data hold their last values.
- Read latency: for a read, rdata=chanbuf_data_r and rvalid[i]=1 in the cycle after chanbuf_clken. rvalid therefore comes 2 cycles after req was sampled. Writes produce no rvalid.
- State IDLE -> LOCKED: when a grant goes to i with lock[i]=1. The burst counter is loaded with 1.
- In LOCKED(owner):
  - Only the owner is eligible; all other requests wait. The owner can be granted every other cycle.
  - Each grant increments the burst counter.
- LOCKED -> IDLE, on the first of:
  - lock[owner]=0 or req[owner] withdrawn for a cycle with no pending grant;
  - burst counter reaching MAX_BURST, in which case release happens on that grant.
- On release the pointer is owner+1. A re-asserted lock must win normal arbitration again.
- Withdrawal: req dropped before gnt is legal and nothing is issued. Inputs may change freely after gnt.
- Simultaneous events: a release and a new grant may happen in the same cycle. The grant is decided with the post-release eligibility, so other requesters are considered immediately.
- A lock asserted without req is ignored. More than one rvalid bit is never set at once.

Decomposition:
- Shared package chanbuf_pkg:
  - ADDR_W and DATA_W defaults;
  - arb_state_t enum {IDLE, LOCKED};
  - the burst-count width constant.
- One sub-module rr_pick:
  - inputs: eligible mask and pointer;
  - outputs: one-hot winner, winner index and a found flag;
  - purely combinational, instantiated once.

Test Plan:
- Single read: req[0]=1, addr=0x05A, RAM word 0x3C. Expect gnt[0] in cycle 1 with chanbuf_clken=1 and addr 0x05A; rvalid[0]=1 and rdata=0x3C in cycle 2.
- Fairness: req=4'b1111 held continuously. Expect grant order 0,1,2,3,0 with no repeats in consecutive cycles and one chanbuf_clken per cycle.
- Write then read: requester 2 writes 0xA5 to 0x1FF, then reads 0x1FF. Expect chanbuf_we=1 only on the write; the read returns 0xA5 on rvalid[2].
- Burst cap: requester 1 holds req and lock while requester 3 requests constantly. Expect exactly 16 grants to 1, then requester 3 granted next and locked=0.
- Early release: lock[1] dropped after 5 grants. Expect locked=0 the next cycle and requester 3 granted.
- Reset mid-read: rst_in=1 in the cycle after a read grant. Expect no rvalid and all outputs 0; the next grant after reset goes to requester 0.
